// File: rtl/fft4_pkg.sv
// Shared definitions for the 4-point DFT engine: data widths, FSM state
// encoding, twiddle constants and the accumulator rounding helper.
package fft4_pkg;

  localparam int unsigned DATA_W = 16;                    // sample width (re/im each)
  localparam int unsigned COEF_W = 17;                    // twiddle width, 1.0 = 2^FRAC_W
  localparam int unsigned FRAC_W = 15;                    // twiddle fraction bits
  localparam int unsigned OUT_W  = DATA_W + 3;            // result width
  localparam int unsigned PROD_W = DATA_W + COEF_W + 1;   // one complex product term
  localparam int unsigned ACC_W  = DATA_W + COEF_W + 3;   // four terms summed

  localparam logic [COEF_W-1:0] TW_ONE       = 17'h08000;
  localparam logic [COEF_W-1:0] TW_MINUS_ONE = 17'h18000;

  localparam logic [ACC_W-1:0] ROUND_HALF = ACC_W'(64'd1 << (FRAC_W - 1));

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCalc,
    StOut
  } state_e;

  // Round half up, drop the twiddle fraction and take the result width.
  // Four samples times |W| <= 1 always fit in OUT_W, so no saturation.
  function automatic logic [OUT_W-1:0] round_frac(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] rounded;
    logic [ACC_W-1:0] shifted;
    rounded = acc + ROUND_HALF;
    shifted = ACC_W'($signed(rounded) >>> FRAC_W);
    return shifted[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/fft4_cmac.sv
// Combinational signed complex multiply x * w.
//   x_re_i, x_im_i : DATA_W signed sample
//   w_re_i, w_im_i : COEF_W signed twiddle
//   p_re_o, p_im_o : PROD_W signed product terms (re = xr*wr - xi*wi, im = xr*wi + xi*wr)
module fft4_cmac
  import fft4_pkg::*;
(
  input  logic [DATA_W-1:0] x_re_i,
  input  logic [DATA_W-1:0] x_im_i,
  input  logic [COEF_W-1:0] w_re_i,
  input  logic [COEF_W-1:0] w_im_i,
  output logic [PROD_W-1:0] p_re_o,
  output logic [PROD_W-1:0] p_im_o
);

  logic signed [PROD_W-1:0] xr, xi, wr, wi;

  always_comb begin
    // Sign-extend everything to the product width so the multiply is exact.
    xr     = PROD_W'($signed(x_re_i));
    xi     = PROD_W'($signed(x_im_i));
    wr     = PROD_W'($signed(w_re_i));
    wi     = PROD_W'($signed(w_im_i));
    p_re_o = xr * wr - xi * wi;
    p_im_o = xr * wi + xi * wr;
  end

endmodule

// File: rtl/fft4_dft_engine.sv
// Sequential 4-point DFT. Loads four complex samples, sweeps the external
// twiddle ROMs over (k,n) for 16 multiply-accumulate cycles, then streams
// X[0..3] out over a valid/ready handshake.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  : sample handshake, in_re_i/in_im_i = x[n]
//   lut_k_o, lut_n_o         : twiddle ROM address (0 outside CALC)
//   twiddle_re_i/_im_i       : combinational ROM data for (lut_k, lut_n)
//   out_valid_o / out_ready_i: result handshake, out_k_o = bin, out_re_o/out_im_o = X[out_k]
//   busy_o                   : high in CALC and OUT
module fft4_dft_engine
  import fft4_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_re_i,
  input  logic [DATA_W-1:0] in_im_i,
  output logic [1:0]        lut_k_o,
  output logic [1:0]        lut_n_o,
  input  logic [COEF_W-1:0] twiddle_re_i,
  input  logic [COEF_W-1:0] twiddle_im_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [1:0]        out_k_o,
  output logic [OUT_W-1:0]  out_re_o,
  output logic [OUT_W-1:0]  out_im_o,
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic [1:0]        load_cnt_q, load_cnt_d;
  logic [3:0]        cnt_q, cnt_d;        // {k, n}, n innermost
  logic [1:0]        out_k_q, out_k_d;
  logic [DATA_W-1:0] samp_re_q [4];
  logic [DATA_W-1:0] samp_re_d [4];
  logic [DATA_W-1:0] samp_im_q [4];
  logic [DATA_W-1:0] samp_im_d [4];
  logic [ACC_W-1:0]  acc_re_q, acc_re_d;
  logic [ACC_W-1:0]  acc_im_q, acc_im_d;
  logic [OUT_W-1:0]  res_re_q [4];
  logic [OUT_W-1:0]  res_re_d [4];
  logic [OUT_W-1:0]  res_im_q [4];
  logic [OUT_W-1:0]  res_im_d [4];

  logic [1:0]        cur_k, cur_n;
  logic [PROD_W-1:0] prod_re, prod_im;
  logic [ACC_W-1:0]  acc_re_sum, acc_im_sum;

  assign cur_k = cnt_q[3:2];
  assign cur_n = cnt_q[1:0];

  fft4_cmac u_cmac (
    .x_re_i (samp_re_q[cur_n]),
    .x_im_i (samp_im_q[cur_n]),
    .w_re_i (twiddle_re_i),
    .w_im_i (twiddle_im_i),
    .p_re_o (prod_re),
    .p_im_o (prod_im)
  );

  // n = 0 starts a fresh bin, so the old accumulator value is dropped.
  always_comb begin
    acc_re_sum = ((cur_n == 2'd0) ? '0 : acc_re_q)
                 + {{(ACC_W - PROD_W){prod_re[PROD_W-1]}}, prod_re};
    acc_im_sum = ((cur_n == 2'd0) ? '0 : acc_im_q)
                 + {{(ACC_W - PROD_W){prod_im[PROD_W-1]}}, prod_im};
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    cnt_d      = cnt_q;
    out_k_d    = out_k_q;
    samp_re_d  = samp_re_q;
    samp_im_d  = samp_im_q;
    acc_re_d   = acc_re_q;
    acc_im_d   = acc_im_q;
    res_re_d   = res_re_q;
    res_im_d   = res_im_q;

    unique case (state_q)
      StIdle, StLoad: begin
        if (in_valid_i) begin
          samp_re_d[load_cnt_q] = in_re_i;
          samp_im_d[load_cnt_q] = in_im_i;
          load_cnt_d            = load_cnt_q + 2'd1;
          if (load_cnt_q == 2'd3) begin
            state_d = StCalc;
            cnt_d   = '0;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StCalc: begin
        acc_re_d = acc_re_sum;
        acc_im_d = acc_im_sum;
        if (cur_n == 2'd3) begin
          res_re_d[cur_k] = round_frac(acc_re_sum);
          res_im_d[cur_k] = round_frac(acc_im_sum);
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = StOut;
          out_k_d = '0;
        end
      end
      StOut: begin
        if (out_ready_i) begin
          out_k_d = out_k_q + 2'd1;
          if (out_k_q == 2'd3) begin
            state_d    = StIdle;
            load_cnt_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      load_cnt_q <= '0;
      cnt_q      <= '0;
      out_k_q    <= '0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        samp_re_q[i] <= '0;
        samp_im_q[i] <= '0;
        res_re_q[i]  <= '0;
        res_im_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      cnt_q      <= cnt_d;
      out_k_q    <= out_k_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      samp_re_q  <= samp_re_d;
      samp_im_q  <= samp_im_d;
      res_re_q   <= res_re_d;
      res_im_q   <= res_im_d;
    end
  end

  always_comb begin
    in_ready_o  = (state_q == StIdle) || (state_q == StLoad);
    busy_o      = (state_q == StCalc) || (state_q == StOut);
    out_valid_o = (state_q == StOut);
    lut_k_o     = (state_q == StCalc) ? cur_k : 2'd0;
    lut_n_o     = (state_q == StCalc) ? cur_n : 2'd0;
    out_k_o     = out_k_q;
    out_re_o    = res_re_q[out_k_q];
    out_im_o    = res_im_q[out_k_q];
  end

endmodule

// File: tb/tb_fft4_dft_engine.sv
// Scoreboard bench for fft4_dft_engine: a twiddle ROM model feeds the DUT,
// a driver pushes reference-model results as it issues frames, and a
// monitor pops and compares on each output handshake.
module tb_fft4_dft_engine;
  import fft4_pkg::*;

  logic              clk, rst_n;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_re, in_im;
  logic [1:0]        lut_k, lut_n;
  logic [COEF_W-1:0] twiddle_re, twiddle_im;
  logic              out_valid, out_ready;
  logic [1:0]        out_k;
  logic [OUT_W-1:0]  out_re, out_im;
  logic              busy;

  fft4_dft_engine dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_re_i      (in_re),
    .in_im_i      (in_im),
    .lut_k_o      (lut_k),
    .lut_n_o      (lut_n),
    .twiddle_re_i (twiddle_re),
    .twiddle_im_i (twiddle_im),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_k_o      (out_k),
    .out_re_o     (out_re),
    .out_im_o     (out_im),
    .busy_o       (busy)
  );

  // Twiddle ROM: W^(k*n mod 4) = 1, -j, -1, +j
  logic [3:0] kn;
  always_comb begin
    kn = lut_k * lut_n;
    twiddle_re = '0;
    twiddle_im = '0;
    case (kn[1:0])
      2'd0: twiddle_re = TW_ONE;
      2'd1: twiddle_im = TW_MINUS_ONE;
      2'd2: twiddle_re = TW_MINUS_ONE;
      default: twiddle_im = TW_ONE;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     failures = 0;
  int     exp_k[$];
  longint exp_re[$];
  longint exp_im[$];
  int     ncyc = 0;
  int     last_acc = 0;
  bit     lat_armed = 0;
  int     bp_mode = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference DFT with integer twiddles scaled by 2^15, then round half up.
  task automatic push_model(input int xr[4], input int xi[4]);
    int wr_t[4] = '{32768, 0, -32768, 0};
    int wi_t[4] = '{0, -32768, 0, 32768};
    for (int k = 0; k < 4; k++) begin
      longint ar = 0, ai = 0;
      for (int n = 0; n < 4; n++) begin
        int m = (k * n) % 4;
        ar += longint'(xr[n]) * wr_t[m] - longint'(xi[n]) * wi_t[m];
        ai += longint'(xr[n]) * wi_t[m] + longint'(xi[n]) * wr_t[m];
      end
      exp_k.push_back(k);
      exp_re.push_back((ar + 16384) >>> 15);
      exp_im.push_back((ai + 16384) >>> 15);
    end
  endtask

  task automatic send_frame(input int xr[4], input int xi[4], input int maxgap);
    push_model(xr, xi);
    for (int n = 0; n < 4; n++) begin
      bit ok = 0;
      in_valid = 1'b0;
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      in_valid = 1'b1;
      in_re = DATA_W'(xr[n]);
      in_im = DATA_W'(xi[n]);
      for (int t = 0; t < 300; t++) begin
        if (in_ready) begin
          @(posedge clk);
          ok = 1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) chk("accept_timeout", n, -1);
      if (ok && n == 3) begin
        last_acc  = ncyc;
        lat_armed = 1;
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    for (t = 0; t < 3000; t++) begin
      if (exp_k.size() == 0 && in_ready) break;
      @(negedge clk);
    end
    if (t == 3000) chk("drain_timeout", exp_k.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_lut"}, {lut_k, lut_n}, 0);
    chk({tag, "_out_k"}, out_k, 0);
    chk({tag, "_out_re"}, out_re, 0);
    chk({tag, "_out_im"}, out_im, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_vals(tag);
    exp_k.delete();
    exp_re.delete();
    exp_im.delete();
    lat_armed = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // out_ready changes just after the active edge
  initial begin
    int rc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0: out_ready = 1'b1;
        1: begin
          if (rc == 5) begin
            out_ready = 1'b1;
            rc = 0;
          end else begin
            out_ready = 1'b0;
            rc++;
          end
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    int  calc_idx = 0;
    bit  stalled = 0;
    logic [1:0]       s_k;
    logic [OUT_W-1:0] s_re, s_im;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        stalled  = 0;
        calc_idx = 0;
        continue;
      end
      if (busy && !out_valid) begin
        chk("lut_sweep", {lut_k, lut_n}, calc_idx);
        calc_idx++;
      end else begin
        chk("lut_idle_zero", {lut_k, lut_n}, 0);
        calc_idx = 0;
      end
      if (busy) chk("in_ready_busy", in_ready, 0);
      if (out_valid) begin
        if (lat_armed) begin
          chk("latency", ncyc - last_acc, 17);
          lat_armed = 0;
        end
        if (stalled) begin
          chk("stall_k", out_k, s_k);
          chk("stall_re", out_re, s_re);
          chk("stall_im", out_im, s_im);
        end
        if (out_ready) begin
          if (exp_k.size() == 0) begin
            chk("unexpected_out", out_k, -1);
          end else begin
            chk("out_k", out_k, exp_k.pop_front());
            chk("out_re", longint'($signed(out_re)), exp_re.pop_front());
            chk("out_im", longint'($signed(out_im)), exp_im.pop_front());
          end
          stalled = 0;
        end else begin
          stalled = 1;
          s_k = out_k;
          s_re = out_re;
          s_im = out_im;
        end
      end else begin
        stalled = 0;
      end
    end
  end

  initial begin
    int xr[4], xi[4];
    logic [15:0] r;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
    #3;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    send_frame('{1000, 0, 0, 0}, '{0, 0, 0, 0}, 0);
    wait_drain();
    send_frame('{1000, 1000, 1000, 1000}, '{0, 0, 0, 0}, 0);
    wait_drain();
    send_frame('{0, 1000, 0, 0}, '{0, 0, 0, 0}, 0);
    wait_drain();
    send_frame('{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768}, 0);
    wait_drain();
    send_frame('{32767, -32768, 32767, -32768}, '{32767, 32767, -32768, -32768}, 1);
    wait_drain();

    for (int f = 0; f < 6; f++) begin
      bp_mode = f % 3;
      for (int i = 0; i < 4; i++) begin
        r = 16'($urandom);
        xr[i] = int'($signed(r));
        r = 16'($urandom);
        xi[i] = int'($signed(r));
      end
      send_frame(xr, xi, 3);
      wait_drain();
    end

    // Abort in CALC at counter 7
    bp_mode = 0;
    send_frame('{123, -456, 789, -1011}, '{5, 6, 7, 8}, 0);
    repeat (7) @(negedge clk);
    chk("mid_calc_cnt", {lut_k, lut_n}, 7);
    do_reset("rst_calc");
    send_frame('{1000, 0, 0, 0}, '{0, 0, 0, 0}, 0);
    wait_drain();

    // Abort in OUT at out_k = 2
    bp_mode = 1;
    send_frame('{-300, 2000, 77, 9}, '{40, -50, 60, -70}, 0);
    begin
      int t;
      for (t = 0; t < 400; t++) begin
        @(negedge clk);
        if (out_valid && out_k == 2'd2) break;
      end
      chk("mid_out_reached", (t < 400) ? 1 : 0, 1);
    end
    do_reset("rst_out");
    bp_mode = 0;
    send_frame('{1000, 0, 0, 0}, '{0, 0, 0, 0}, 0);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
